// File: rtl/fifo8x9_ctrl.sv
// Control FSM for an 8-deep, 9-bit FIFO: gates storage write/read strobes,
// drives pointer clears, tracks occupancy and latches sticky error flags.
module fifo8x9_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic             wren,
  output logic             WrInc,
  output logic             rden,
  output logic             RdInc,
  output logic             RdPtrClr,
  output logic             WrPtrClr,
  output logic             push_ready,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] LP_FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic             w_ptr_clr;
  logic             w_flush_run;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_push_ready;

  assign w_full  = (r_count == LP_FULL_CNT);
  assign w_empty = (r_count == '0);

  // Next state and per-cycle strobes; a pop frees the slot a same-cycle push needs.
  always_comb begin
    w_next_state = r_state;
    w_push_acc   = 1'b0;
    w_pop_acc    = 1'b0;
    w_ptr_clr    = 1'b0;
    w_flush_run  = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    w_push_ready = 1'b0;
    case (r_state)
      INIT: begin
        w_ptr_clr    = 1'b1;
        w_next_state = RUN;
      end
      RUN: begin
        if (flush) begin
          w_ptr_clr    = 1'b1;
          w_flush_run  = 1'b1;
          w_next_state = INIT;
        end else begin
          w_pop_acc    = pop && !w_empty;
          w_push_acc   = push && (!w_full || w_pop_acc);
          w_push_ready = !w_full || (pop && !w_empty);
          w_ovf_set    = push && w_full && !w_pop_acc;
          w_unf_set    = pop && w_empty;
        end
      end
      default: w_next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_dout_valid <= w_pop_acc;
      if (w_flush_run) begin
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_push_acc && !w_pop_acc) begin
          r_count <= r_count + LP_ONE;
        end else if (w_pop_acc && !w_push_acc) begin
          r_count <= r_count - LP_ONE;
        end
        r_overflow  <= r_overflow  | w_ovf_set;
        r_underflow <= r_underflow | w_unf_set;
      end
    end
  end

  assign wren       = w_push_acc;
  assign WrInc      = w_push_acc;
  assign rden       = w_pop_acc;
  assign RdInc      = w_pop_acc;
  assign RdPtrClr   = w_ptr_clr;
  assign WrPtrClr   = w_ptr_clr;
  assign push_ready = w_push_ready;
  assign dout_valid = r_dout_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Randomized bench for fifo8x9_ctrl against an occupancy-level reference model.
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst, push, pop, flush;
  logic       wren, WrInc, rden, RdInc, RdPtrClr, WrPtrClr;
  logic       push_ready, dout_valid, full, empty, overflow, underflow;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: occupancy as a plain integer plus phase and flags.
  bit m_init;
  int m_cnt;
  bit m_dv, m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo8x9_ctrl #(.DEPTH(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wren(wren), .WrInc(WrInc), .rden(rden), .RdInc(RdInc),
    .RdPtrClr(RdPtrClr), .WrPtrClr(WrPtrClr), .push_ready(push_ready),
    .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic cycle(input bit r, input bit pu, input bit po, input bit fl, input bit chk);
    bit run, pop_ok, push_ok, clr;
    @(negedge clk);
    rst = r; push = pu; pop = po; flush = fl;
    #1;
    run     = !m_init;
    pop_ok  = run && !fl && po && (m_cnt > 0);
    push_ok = run && !fl && pu && ((m_cnt < 8) || pop_ok);
    clr     = m_init || (run && fl);
    if (chk) begin
      check_eq("wren",       32'(wren),       32'(push_ok));
      check_eq("WrInc",      32'(WrInc),      32'(push_ok));
      check_eq("rden",       32'(rden),       32'(pop_ok));
      check_eq("RdInc",      32'(RdInc),      32'(pop_ok));
      check_eq("RdPtrClr",   32'(RdPtrClr),   32'(clr));
      check_eq("WrPtrClr",   32'(WrPtrClr),   32'(clr));
      check_eq("push_ready", 32'(push_ready), 32'(run && !fl && ((m_cnt < 8) || (po && m_cnt > 0))));
      check_eq("dout_valid", 32'(dout_valid), 32'(m_dv));
      check_eq("count",      32'(count),      32'(m_cnt));
      check_eq("full",       32'(full),       32'(m_cnt == 8));
      check_eq("empty",      32'(empty),      32'(m_cnt == 0));
      check_eq("overflow",   32'(overflow),   32'(m_ovf));
      check_eq("underflow",  32'(underflow),  32'(m_unf));
      check_eq("inc_vs_clr", 32'((WrInc | RdInc) & (RdPtrClr | WrPtrClr)), 32'(0));
    end
    @(posedge clk);
    if (r) begin
      m_init = 1; m_cnt = 0; m_dv = 0; m_ovf = 0; m_unf = 0;
    end else if (m_init) begin
      m_init = 0; m_dv = 0;
    end else if (fl) begin
      m_init = 1; m_cnt = 0; m_dv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (pu && !push_ok) m_ovf = 1;
      if (po && m_cnt == 0) m_unf = 1;
      m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
      m_dv  = pop_ok;
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    m_init = 1; m_cnt = 0; m_dv = 0; m_ovf = 0; m_unf = 0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0);
    // INIT cycle: clears high, push ignored
    cycle(0, 1, 0, 0, 1);
    // fill to full, then overflow, then push+pop at full
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // drain, then underflow and push+pop from empty
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // reach 5 words, flush with push+pop asserted, observe INIT
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 1, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // reach 3 words, reset mid-stream with flush also high
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(1, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) == 0), 1);
    end
    cycle(0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo8x9_ctrl.md
FIFO8X9_CTRL -- requirements
Module: fifo8x9_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter DEPTH, default 8, SHALL set the storage depth; only 8 is supported.
REQ-003 Parameter CNT_W, default 4, SHALL set the count width; it covers 0..DEPTH.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 push  input  1  producer request to write one word this cycle.
REQ-007 pop  input  1  consumer request to read one word this cycle.
REQ-008 flush  input  1  discard all contents and clear both pointers.
REQ-009 wren, WrInc  output  1 each  storage write enable and write-pointer increment.
REQ-010 rden, RdInc  output  1 each  storage read enable and read-pointer increment.
REQ-011 RdPtrClr, WrPtrClr  output  1 each  storage pointer clears.
REQ-012 push_ready  output  1  high when a push would be accepted.
REQ-013 dout_valid  output  1  storage DataOut holds a popped word this cycle.
REQ-014 full, empty  output  1 each  occupancy flags.
REQ-015 count  output  CNT_W  words held, 0..8.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 The FSM SHALL have states INIT and RUN; the reset state SHALL be INIT.
REQ-018 INIT SHALL last exactly one cycle, asserting RdPtrClr=WrPtrClr=1, then go to RUN.
REQ-019 In INIT, push_ready SHALL be 0 and no push or pop SHALL be accepted.
REQ-020 In RUN with flush=1, the block SHALL assert RdPtrClr=WrPtrClr=1 and go to INIT on the next edge.
REQ-021 On that flush edge, count SHALL become 0 and overflow/underflow SHALL clear; flush SHALL override push and pop.
REQ-022 A pop SHALL be accepted in RUN when pop=1, flush=0 and empty=0.
REQ-023 A push SHALL be accepted in RUN when push=1, flush=0, and either full=0 or a pop is accepted the same cycle.
REQ-024 An accepted push SHALL assert wren=1 and WrInc=1 combinationally in the same cycle.
REQ-025 An accepted pop SHALL assert rden=1 and RdInc=1 combinationally in the same cycle.
REQ-026 wren, WrInc, rden and RdInc SHALL be 0 in every cycle without an accepted push or pop.
REQ-027 An Inc output and a PtrClr output SHALL never be high in the same cycle.
REQ-028 dout_valid SHALL be registered: 1 in the cycle after an accepted pop, 0 otherwise.
REQ-029 count SHALL update on the edge: +1 for push only, -1 for pop only, unchanged for both or neither.
REQ-030 full SHALL equal (count==8); empty SHALL equal (count==0); both SHALL derive from registered count.
REQ-031 push_ready SHALL equal (state==RUN && !flush && (!full || (pop && !empty))).
REQ-032 push=1 with full=1 and no accepted pop, in RUN without flush, SHALL set overflow; the push is dropped.
REQ-033 pop=1 with empty=1, in RUN without flush, SHALL set underflow; a simultaneous push is still accepted.
REQ-034 Pointer wrap 7->0 is handled by the storage; count SHALL never exceed 8 or go below 0.

Reset
REQ-035 On an rst edge: state=INIT, count=0, dout_valid=0, overflow=0, underflow=0.
REQ-036 rst SHALL take priority over every input, including mid-operation and during flush.
REQ-037 The cycle after reset SHALL show RdPtrClr=WrPtrClr=1, empty=1, push_ready=0.

Verification
REQ-038 Reset, then 8 pushes -> wren/WrInc each cycle, count 1..8, full=1 after the 8th, push_ready=0.
REQ-039 From full, a 9th push alone -> no wren, overflow=1, count stays 8.
REQ-040 From full, push+pop together -> wren/WrInc/rden/RdInc all 1, count stays 8, dout_valid=1 next cycle.
REQ-041 From empty, pop alone -> rden=0, underflow=1; push+pop together -> push only, count=1.
REQ-042 With count=5, flush -> both PtrClr=1 two consecutive cycles (RUN, then INIT), count=0, flags cleared.
REQ-043 With count=3, rst mid-stream -> count=0, dout_valid=0, INIT PtrClr cycle, then RUN.
